load_store_unit: RTL
====================

# load_store_unit

Sequential load/store unit between the pipeline MEM stage and the byte-addressable data memory. Accepts one RV32I load or store at a time, issues the memory transactions, and returns a sign- or zero-extended load result. Sub-word stores use read-modify-write, because the data memory always writes four bytes. Stalls the MEM stage through `req_ready` while a request is in flight.

## Interface
- `ADDR_W`, default 32: address width.
- `XLEN`, default 32: data width; fixed at 32 for the 4-byte memory port.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in `IDLE`.
- `req_we` in 1: 1 means store, 0 means load.
- `req_funct3` in 3: RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in XLEN: store data, taken from the low bytes.
- `rsp_valid` out 1: one-cycle pulse that completes the request.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and errors; held until the next response.
- `rsp_err` out 1: qualifies `rsp_valid`; set for an illegal funct3 or a trapped misalignment.
- `mem_rd` out 1, `mem_wr` out 1, `mem_cs_n` out 1: data memory controls; `mem_cs_n` is active-low.
- `mem_addr` out ADDR_W, `mem_wdata` out XLEN: data memory address and write data.
- `mem_rdata` in XLEN: data memory read data; combinational, valid only while `mem_rd=1` and `mem_cs_n=0`.

## Operation
- States: `IDLE`, `RD`, `WR`, `RESP`.
- `IDLE`:
  - `req_ready=1`, `mem_cs_n=1`, `mem_rd=0`, `mem_wr=0`.
  - On `req_valid`, the unit latches `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- Transition out of `IDLE`:
  - Illegal funct3 (load 3/6/7, store ≥3): go to `RESP` with `err=1`.
  - Load, SB or SH: go to `RD`.
  - SW: go to `WR`.
- `RD`:
  - Drives `mem_cs_n=0`, `mem_rd=1`, `mem_addr`=latched address.
  - Captures `mem_rdata` at the clock edge.
  - Next state is `RESP` for a load, `WR` for SB/SH.
- `WR`:
  - Drives `mem_cs_n=0`, `mem_wr=1`, `mem_addr`=latched address.
  - `mem_wdata`:
    - SW: `wdata`.
    - SH: {captured[31:16], wdata[15:0]}.
    - SB: {captured[31:8], wdata[7:0]}.
  - Next state is `RESP`.
- `RESP`:
  - `rsp_valid=1` for one cycle.
  - Next state is `IDLE`; no response backpressure.
- Load extraction, byte lane 0 of `mem_rdata` at the latched address:
  - LB: sext of [7:0].
  - LBU: zext of [7:0].
  - LH: sext of [15:0].
  - LHU: zext of [15:0].
  - LW: all 32 bits.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_cs_n=1`.

## Timing
- Reset values: state `IDLE`, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_cs_n=1`, `mem_rd=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`.
- Cycle A is the accept cycle; `rsp_valid` is asserted at:
  - Load: A+2.
  - SW: A+2.
  - SB/SH: A+3.
  - Error: A+1.
- `req_ready` is low from A+1 until `IDLE` is re-entered, so back-to-back requests are accepted in the cycle after `RESP`.
- `rst` in any state returns to `IDLE` at the next edge. A pending `WR` is dropped and no response is issued.
- `req_valid` in a non-`IDLE` state is ignored, and the request is not latched.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, make no memory access and respond at A+1 with `rsp_err=1` and `rsp_rdata=0`.
  - Undefined: misaligned accesses are performed normally at the raw byte address, which the byte-addressable memory supports.

## Structure
- Shared package `lsu_pkg` holds:
  - the funct3 constants;
  - the state encoding (`IDLE`=0, `RD`=1, `WR`=2, `RESP`=3);
  - the misalignment check function.
- Sub-module `lsu_align`: combinational load extraction and store merge.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Reset, then `SW` to 0x10 with data 0xDEADBEEF: `mem_wr` pulse at A+1 with addr 0x10, `rsp_valid` at A+2; a following `LW` at 0x10 returns 0xDEADBEEF at its A+2.
- Memory word at 0x20 holds 0x11223344; `SB` 0x20 with data 0xAB: `RD` at A+1, `WR` at A+2 with `mem_wdata`=0x112233AB, `rsp_valid` at A+3.
- Memory at 0x30 holds 0x000080F0: `LB` returns 0xFFFFFFF0, `LBU` returns 0x000000F0, `LH` returns 0xFFFF80F0, `LHU` returns 0x000080F0.
- Load with funct3=3: `rsp_valid`+`rsp_err` at A+1, `rsp_rdata`=0, no `mem_cs_n` low at any point.
- `LW` at 0x22:
  - Macro defined: `rsp_err` at A+1, no memory access.
  - Macro undefined: bytes 0x22..0x25 are returned at A+2.
- `SH` to 0x40, then `rst` asserted in the `RD` cycle: no `mem_wr` is ever issued, no `rsp_valid`, and `req_ready=1` after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, FSM encoding
// and the alignment/legality helpers used by the request decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we)
      return (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    return (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W) &&
           (funct3 != F3_BU) && (funct3 != F3_HU);
  endfunction

  // Same funct3 encodings cover both loads and stores for width selection.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'd0;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational load extraction (sign/zero extension from byte lane 0) and
// read-modify-write merge of sub-word store data into the old memory word.
module load_store_unit_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] load_word,
  input  logic [XLEN-1:0] store_old,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){load_word[7]}}, load_word[7:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, load_word[7:0]};
      F3_H:    load_data = {{(XLEN-16){load_word[15]}}, load_word[15:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, load_word[15:0]};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    store_word = store_data;
    case (funct3)
      F3_B:    store_word = {store_old[XLEN-1:8], store_data[7:0]};
      F3_H:    store_word = {store_old[XLEN-1:16], store_data[15:0]};
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential RV32I load/store unit; sub-word stores use read-modify-write.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | ready for a request, memory idle
// RD    | memory read (loads, and old word for SB/SH)
// WR    | memory write of full or merged word
// RESP  | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_cs_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   store_word;
  logic              misalign_trap;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misalign_trap = 1'b0;
`endif

  load_store_unit_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_q),
    .load_word  (mem_rdata),
    .store_old  (rdata_q),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (is_illegal(req_we, req_funct3) || misalign_trap) begin
              state     <= ST_RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && (req_funct3 == F3_W)) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          rdata_q <= mem_rdata;
          if (we_q) begin
            state <= ST_WR;
          end else begin
            state     <= ST_RESP;
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
          end
        end
        ST_WR: begin
          state     <= ST_RESP;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address and data buses are forced to zero whenever the memory is deselected.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_rd    = (state == ST_RD);
    mem_wr    = (state == ST_WR);
    mem_cs_n  = !(mem_rd || mem_wr);
    mem_addr  = mem_cs_n ? '0 : addr_q;
    mem_wdata = mem_wr ? store_word : '0;
  end

endmodule
